// File: rtl/oldland_cache_pkg.sv
// Shared definitions for the oldland cache ways and the maintenance sequencer.
package oldland_cache_pkg;

    localparam int unsigned CACHE_LINE_SIZE  = 32;
    localparam int unsigned CACHE_WAY_SIZE   = 4096;
    localparam int unsigned CACHE_INDEX_BITS = $clog2(CACHE_WAY_SIZE / CACHE_LINE_SIZE);

    localparam logic OP_INVAL = 1'b0;
    localparam logic OP_FLUSH = 1'b1;

    // One-hot encoding, matching the way controller FSM.
    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_ISSUE   = 5'b00010,
        ST_WAIT    = 5'b00100,
        ST_ADVANCE = 5'b01000,
        ST_DONE    = 5'b10000
    } maint_state_e;

endpackage

// File: rtl/oldland_cache_maint_if.sv
// Request/response and per-way operation bus of the cache maintenance sequencer.
interface oldland_cache_maint_if #(
    parameter int unsigned NR_WAYS    = 2,
    parameter int unsigned INDEX_BITS = 7
);
    logic                  req;
    logic                  req_flush;
    logic                  req_all;
    logic [INDEX_BITS-1:0] req_index;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic                  cpu_stall;
    logic [NR_WAYS-1:0]    way_sel;
    logic [INDEX_BITS-1:0] c_index;
    logic                  c_inval;
    logic                  c_flush;
    logic [NR_WAYS-1:0]    cacheop_complete;

    modport master (
        output req, req_flush, req_all, req_index, cacheop_complete,
        input  busy, done, error, cpu_stall, way_sel, c_index, c_inval, c_flush
    );

    modport slave (
        input  req, req_flush, req_all, req_index, cacheop_complete,
        output busy, done, error, cpu_stall, way_sel, c_index, c_inval, c_flush
    );

endinterface

// File: rtl/oldland_maint_timeout.sv
// Loadable down-counter; expired_c is high once the count has reached zero.
module oldland_maint_timeout #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             expired_c
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_c = (count_q == '0);

endmodule

// File: rtl/oldland_cache_maint.sv
// Sequences invalidate/flush operations over every way (and optionally every index)
// of an oldland cache, stalling the CPU while active.
module oldland_cache_maint
    import oldland_cache_pkg::*;
#(
    parameter int unsigned NR_WAYS        = 2,
    parameter int unsigned INDEX_BITS     = CACHE_INDEX_BITS,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter bit          READ_ONLY      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    oldland_cache_maint_if.slave  bus
);

    localparam int unsigned WAY_BITS = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
    localparam int unsigned TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INDEX_BITS-1:0] LAST_INDEX = '1;
    localparam logic [WAY_BITS-1:0]   LAST_WAY   = WAY_BITS'(NR_WAYS - 1);

    maint_state_e          state_q, state_d;
    logic [INDEX_BITS-1:0] index_q, index_d;
    logic [WAY_BITS-1:0]   way_q, way_d;
    logic                  op_flush_q, op_flush_d;
    logic                  op_all_q, op_all_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  inval_q, inval_d;
    logic                  flush_q, flush_d;
    logic                  tmo_load_c, tmo_dec_c, tmo_expired_c;
    logic                  complete_c;

    oldland_maint_timeout #(.WIDTH(TMO_BITS)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .load      (tmo_load_c),
        .load_val  (TMO_BITS'(TIMEOUT_CYCLES - 1)),
        .dec       (tmo_dec_c),
        .expired_c (tmo_expired_c)
    );

    assign complete_c = bus.cacheop_complete[way_q];

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        way_d      = way_q;
        op_flush_d = op_flush_q;
        op_all_d   = op_all_q;
        err_d      = err_q;
        tmo_load_c = 1'b0;
        tmo_dec_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    op_flush_d = bus.req_flush;
                    op_all_d   = bus.req_all;
                    index_d    = bus.req_all ? '0 : bus.req_index;
                    way_d      = '0;
                    err_d      = 1'b0;
                    state_d    = (READ_ONLY && (bus.req_flush == OP_FLUSH)) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_load_c = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A stuck way is skipped so one bad way cannot hang the CPU.
                if (complete_c) begin
                    state_d = ST_ADVANCE;
                end else if (tmo_expired_c) begin
                    err_d   = 1'b1;
                    state_d = ST_ADVANCE;
                end else begin
                    tmo_dec_c = 1'b1;
                end
            end
            ST_ADVANCE: begin
                if (way_q == LAST_WAY) begin
                    way_d = '0;
                    if (!op_all_q || (index_q == LAST_INDEX)) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + INDEX_BITS'(1);
                        state_d = ST_ISSUE;
                    end
                end else begin
                    way_d   = way_q + WAY_BITS'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_DONE) && err_d;
        inval_d = (state_d == ST_ISSUE) && (op_flush_d == OP_INVAL);
        flush_d = (state_d == ST_ISSUE) && (op_flush_d == OP_FLUSH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            way_q      <= '0;
            op_flush_q <= 1'b0;
            op_all_q   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            inval_q    <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            way_q      <= way_d;
            op_flush_q <= op_flush_d;
            op_all_q   <= op_all_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            inval_q    <= inval_d;
            flush_q    <= flush_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.cpu_stall = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.c_inval   = inval_q;
    assign bus.c_flush   = flush_q;
    assign bus.c_index   = index_q;
    assign bus.way_sel   = ((state_q == ST_ISSUE) || (state_q == ST_WAIT))
                           ? (NR_WAYS'(1) << way_q) : '0;

endmodule

// File: tb/tb_oldland_cache_maint.sv
// Scoreboard bench for oldland_cache_maint: a writeback instance and a read-only instance.
module tb_oldland_cache_maint;

    typedef struct packed {
        logic       flush;
        logic [1:0] way_sel;
        logic [2:0] idx;
    } strobe_t;

    logic clk;
    logic rst;

    oldland_cache_maint_if #(.NR_WAYS(2), .INDEX_BITS(3)) mif ();
    oldland_cache_maint_if #(.NR_WAYS(2), .INDEX_BITS(3)) rif ();

    oldland_cache_maint #(.NR_WAYS(2), .INDEX_BITS(3), .TIMEOUT_CYCLES(8), .READ_ONLY(1'b0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    oldland_cache_maint #(.NR_WAYS(2), .INDEX_BITS(3), .TIMEOUT_CYCLES(8), .READ_ONLY(1'b1)) u_ro (
        .clk (clk),
        .rst (rst),
        .bus (rif)
    );

    int      checks = 0;
    int      failures = 0;
    strobe_t exp_strobe[$];
    strobe_t ro_exp_strobe[$];
    logic    exp_err[$];
    logic    ro_exp_err[$];
    int      delay[2];
    bit      stale = 1'b0;
    bit      track_busy = 1'b0;
    int      busy_low_cnt = 0;
    int      done_cnt = 0, ro_done_cnt = 0, base_done = 0;
    int      strobe_cnt = 0, ro_strobe_cnt = 0;
    time     t_done, ro_t_done, t_req;
    int      cd = 0, cur_way = 0, ro_cd = 0, ro_way = 0;
    strobe_t e, re;
    logic    ee, ree;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Way model + scoreboard for the writeback instance.
    initial begin
        forever begin
            @(negedge clk);
            mif.cacheop_complete = '0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) mif.cacheop_complete[cur_way] = 1'b1;
            end
            if (mif.c_inval || mif.c_flush) begin
                strobe_cnt++;
                checks++;
                if (exp_strobe.size() == 0) begin
                    failures++;
                    $display("FAIL strobe_unexpected: got inval=%b flush=%b way_sel=%b idx=%0d, expected no strobe",
                             mif.c_inval, mif.c_flush, mif.way_sel, mif.c_index);
                end else begin
                    e = exp_strobe.pop_front();
                    if ({mif.c_flush, mif.c_inval, mif.way_sel, mif.c_index} !== {e.flush, ~e.flush, e.way_sel, e.idx}) begin
                        failures++;
                        $display("FAIL strobe: got flush=%b inval=%b way_sel=%b idx=%0d, expected flush=%b inval=%b way_sel=%b idx=%0d",
                                 mif.c_flush, mif.c_inval, mif.way_sel, mif.c_index, e.flush, ~e.flush, e.way_sel, e.idx);
                    end
                end
                cur_way = mif.way_sel[1] ? 1 : 0;
                cd = delay[cur_way];
                if (stale) mif.cacheop_complete[cur_way] = 1'b1;
            end
            if (track_busy && !mif.busy) busy_low_cnt++;
            if (mif.done) begin
                done_cnt++;
                t_done = $time;
                track_busy = 1'b0;
                checks++;
                if (exp_err.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected: got done with error=%b, expected no done", mif.error);
                end else begin
                    ee = exp_err.pop_front();
                    if (mif.error !== ee) begin
                        failures++;
                        $display("FAIL done_error: got %b expected %b", mif.error, ee);
                    end
                end
            end
            checks++;
            if (mif.cpu_stall !== mif.busy) begin
                failures++;
                $display("FAIL cpu_stall: got %b expected %b", mif.cpu_stall, mif.busy);
            end
        end
    end

    // Way model + scoreboard for the read-only instance; ways answer one cycle after the strobe.
    initial begin
        forever begin
            @(negedge clk);
            rif.cacheop_complete = '0;
            if (ro_cd > 0) begin
                ro_cd--;
                if (ro_cd == 0) rif.cacheop_complete[ro_way] = 1'b1;
            end
            if (rif.c_inval || rif.c_flush) begin
                ro_strobe_cnt++;
                checks++;
                if (ro_exp_strobe.size() == 0) begin
                    failures++;
                    $display("FAIL ro_strobe_unexpected: got inval=%b flush=%b way_sel=%b, expected no strobe",
                             rif.c_inval, rif.c_flush, rif.way_sel);
                end else begin
                    re = ro_exp_strobe.pop_front();
                    if ({rif.c_flush, rif.c_inval, rif.way_sel, rif.c_index} !== {re.flush, ~re.flush, re.way_sel, re.idx}) begin
                        failures++;
                        $display("FAIL ro_strobe: got flush=%b inval=%b way_sel=%b idx=%0d, expected flush=%b inval=%b way_sel=%b idx=%0d",
                                 rif.c_flush, rif.c_inval, rif.way_sel, rif.c_index, re.flush, ~re.flush, re.way_sel, re.idx);
                    end
                end
                ro_way = rif.way_sel[1] ? 1 : 0;
                ro_cd = 1;
            end
            if (rif.done) begin
                ro_done_cnt++;
                ro_t_done = $time;
                checks++;
                if (ro_exp_err.size() == 0) begin
                    failures++;
                    $display("FAIL ro_done_unexpected: got done with error=%b, expected no done", rif.error);
                end else begin
                    ree = ro_exp_err.pop_front();
                    if (rif.error !== ree) begin
                        failures++;
                        $display("FAIL ro_done_error: got %b expected %b", rif.error, ree);
                    end
                end
            end
        end
    end

    function automatic void push_strobe(input bit ro, input logic flush, input int way, input int idx);
        strobe_t s;
        s.flush   = flush;
        s.way_sel = (way == 0) ? 2'b01 : 2'b10;
        s.idx     = 3'(idx);
        if (ro) ro_exp_strobe.push_back(s);
        else    exp_strobe.push_back(s);
    endfunction

    task automatic drive_req(input bit ro, input logic flush, input logic all, input logic [2:0] idx);
        @(negedge clk);
        base_done = ro ? ro_done_cnt : done_cnt;
        t_req = $time;
        if (ro) begin
            rif.req = 1'b1; rif.req_flush = flush; rif.req_all = all; rif.req_index = idx;
        end else begin
            mif.req = 1'b1; mif.req_flush = flush; mif.req_all = all; mif.req_index = idx;
        end
        @(negedge clk);
        if (ro) rif.req = 1'b0;
        else    mif.req = 1'b0;
    endtask

    task automatic wait_done(input bit ro, input int exp_cycle, input string name);
        int n = 0;
        int lat;
        while (((ro ? ro_done_cnt : done_cnt) == base_done) && (n < 1000)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((ro ? ro_done_cnt : done_cnt) == base_done) begin
            failures++;
            $display("FAIL %s_done_timeout: got no done after %0d cycles, expected done", name, n);
        end else begin
            lat = int'(((ro ? ro_t_done : t_done) - t_req) / 10) + 1;
            checks++;
            if (lat != exp_cycle) begin
                failures++;
                $display("FAIL %s_latency: got done at cycle %0d expected %0d", name, lat, exp_cycle);
            end
        end
        checks++;
        if ((ro ? ro_exp_strobe.size() : exp_strobe.size()) != 0) begin
            failures++;
            $display("FAIL %s_missing_strobes: got %0d outstanding expected 0", name,
                     ro ? ro_exp_strobe.size() : exp_strobe.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({mif.busy, mif.done, mif.error, mif.cpu_stall, mif.way_sel, mif.c_index, mif.c_inval, mif.c_flush} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b way_sel=%b idx=%0d inval=%b flush=%b expected all 0",
                     mif.busy, mif.done, mif.error, mif.way_sel, mif.c_index, mif.c_inval, mif.c_flush);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_inval_single();
        delay[0] = 1; delay[1] = 1;
        push_strobe(0, 1'b0, 0, 5);
        push_strobe(0, 1'b0, 1, 5);
        exp_err.push_back(1'b0);
        drive_req(0, 1'b0, 1'b0, 3'd5);
        wait_done(0, 8, "inval_single");
    endtask

    task automatic test_flush_all();
        int base;
        delay[0] = 1; delay[1] = 4;
        for (int i = 0; i < 8; i++) begin
            push_strobe(0, 1'b1, 0, i);
            push_strobe(0, 1'b1, 1, i);
        end
        exp_err.push_back(1'b0);
        busy_low_cnt = 0;
        base = strobe_cnt;
        drive_req(0, 1'b1, 1'b1, 3'd6);
        track_busy = 1'b1;
        wait_done(0, 74, "flush_all");
        repeat (4) @(negedge clk);
        checks++;
        if (busy_low_cnt != 0) begin
            failures++;
            $display("FAIL flush_all_busy: got %0d cycles with busy low expected 0", busy_low_cnt);
        end
        checks++;
        if ((strobe_cnt - base) != 16 || done_cnt != base_done + 1) begin
            failures++;
            $display("FAIL flush_all_counts: got strobes=%0d dones=%0d expected 16 and 1",
                     strobe_cnt - base, done_cnt - base_done);
        end
    endtask

    task automatic test_timeout();
        delay[0] = 0; delay[1] = 1;
        push_strobe(0, 1'b0, 0, 2);
        push_strobe(0, 1'b0, 1, 2);
        exp_err.push_back(1'b1);
        drive_req(0, 1'b0, 1'b0, 3'd2);
        wait_done(0, 15, "timeout");
        delay[0] = 1; delay[1] = 1;
        push_strobe(0, 1'b1, 0, 4);
        push_strobe(0, 1'b1, 1, 4);
        exp_err.push_back(1'b0);
        drive_req(0, 1'b1, 1'b0, 3'd4);
        wait_done(0, 8, "after_timeout");
    endtask

    task automatic test_reset_mid_wait();
        delay[0] = 0; delay[1] = 1;
        push_strobe(0, 1'b0, 0, 7);
        drive_req(0, 1'b0, 1'b0, 3'd7);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mif.way_sel !== 2'b00) begin
            failures++;
            $display("FAIL rst_way_sel: got %b expected 00", mif.way_sel);
        end
        checks++;
        if ({mif.busy, mif.cpu_stall} !== 2'b00) begin
            failures++;
            $display("FAIL rst_busy: got busy=%b stall=%b expected 0 0", mif.busy, mif.cpu_stall);
        end
        checks++;
        if ({mif.c_inval, mif.c_flush, mif.done, mif.c_index} !== '0) begin
            failures++;
            $display("FAIL rst_strobes: got inval=%b flush=%b done=%b idx=%0d expected 0",
                     mif.c_inval, mif.c_flush, mif.done, mif.c_index);
        end
        exp_strobe.delete();
        exp_err.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        delay[0] = 1; delay[1] = 1;
        push_strobe(0, 1'b0, 0, 6);
        push_strobe(0, 1'b0, 1, 6);
        exp_err.push_back(1'b0);
        drive_req(0, 1'b0, 1'b0, 3'd6);
        wait_done(0, 8, "after_reset");
    endtask

    task automatic test_read_only();
        ro_exp_err.push_back(1'b0);
        drive_req(1, 1'b1, 1'b0, 3'd1);
        wait_done(1, 2, "ro_flush");
        push_strobe(1, 1'b0, 0, 3);
        push_strobe(1, 1'b0, 1, 3);
        ro_exp_err.push_back(1'b0);
        drive_req(1, 1'b0, 1'b0, 3'd3);
        wait_done(1, 8, "ro_inval");
    endtask

    task automatic test_back_to_back();
        int  base;
        bit  seen = 1'b0;
        int  lat;
        delay[0] = 1; delay[1] = 2;
        stale = 1'b1;
        push_strobe(0, 1'b0, 0, 1);
        push_strobe(0, 1'b0, 1, 1);
        exp_err.push_back(1'b0);
        base = strobe_cnt;
        drive_req(0, 1'b0, 1'b0, 3'd1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            mif.req = 1'b1; mif.req_flush = 1'b1; mif.req_all = 1'b1;
            if (mif.done) begin
                seen = 1'b1;
                break;
            end
        end
        @(negedge clk);
        mif.req = 1'b0;
        stale = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (!seen || done_cnt != base_done + 1) begin
            failures++;
            $display("FAIL b2b_done: got seen=%b dones=%0d expected 1 and 1", seen, done_cnt - base_done);
        end else begin
            lat = int'((t_done - t_req) / 10) + 1;
            checks++;
            if (lat != 9) begin
                failures++;
                $display("FAIL b2b_latency: got done at cycle %0d expected 9", lat);
            end
        end
        checks++;
        if ((strobe_cnt - base) != 2 || exp_strobe.size() != 0) begin
            failures++;
            $display("FAIL b2b_strobes: got %0d strobes (%0d outstanding) expected 2 (0)",
                     strobe_cnt - base, exp_strobe.size());
        end
        checks++;
        if ({mif.busy, mif.way_sel} !== 3'b000) begin
            failures++;
            $display("FAIL b2b_idle: got busy=%b way_sel=%b expected 0 00", mif.busy, mif.way_sel);
        end
    endtask

    initial begin
        rst = 1'b0;
        mif.req = 1'b0; mif.req_flush = 1'b0; mif.req_all = 1'b0; mif.req_index = '0;
        mif.cacheop_complete = '0;
        rif.req = 1'b0; rif.req_flush = 1'b0; rif.req_all = 1'b0; rif.req_index = '0;
        rif.cacheop_complete = '0;
        delay[0] = 1; delay[1] = 1;

        test_reset();
        test_inval_single();
        test_flush_all();
        test_timeout();
        test_reset_mid_wait();
        test_read_only();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
